// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC sequencer: array geometry, lane width
// and the controller state encoding.
package mac_pkg;

  localparam int ARR_N  = 4;
  localparam int LANE_W = 8;
  localparam int BUS_W  = ARR_N * LANE_W;
  localparam int ROW_W  = $clog2(ARR_N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN
  } state_t;

  // Byte j of a bus sits at the most-significant end for j = 0.
  function automatic logic [LANE_W-1:0] lane_byte(input logic [BUS_W-1:0] bus, input int j);
    return bus[BUS_W-1-LANE_W*j -: LANE_W];
  endfunction

endpackage

// File: rtl/mac_skew.sv
// Input skew delay line: lane j delays its byte and valid by j+1 cycles so the
// array sees a diagonal wavefront.
module mac_skew
  import mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [BUS_W-1:0] in_data,
  output logic [BUS_W-1:0] out_data,
  output logic [ARR_N-1:0] out_valid,
  output logic             pending
);

  logic [ARR_N-1:0] lane_pending;

  for (genvar j = 0; j < ARR_N; j++) begin : g_lane
    logic [LANE_W-1:0] dq [j+1];
    logic [j:0]        vq;

    // Bubbles carry zero data so idle columns present a clean zero byte.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= j; k++) dq[k] <= '0;
        vq <= '0;
      end else begin
        dq[0] <= in_valid ? lane_byte(in_data, j) : '0;
        vq[0] <= in_valid;
        for (int k = 1; k <= j; k++) begin
          dq[k] <= dq[k-1];
          vq[k] <= vq[k-1];
        end
      end
    end

    assign out_data[BUS_W-1-LANE_W*j -: LANE_W] = dq[j];
    assign out_valid[j]    = vq[j];
    assign lane_pending[j] = |vq;
  end

  assign pending = |lane_pending;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for a 4x4 MAC array: loads four weight rows, streams activation
// vectors through the skew line, then waits for every row to report all results.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DRAIN_TO = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] vec_cnt,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [BUS_W-1:0] w_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [BUS_W-1:0] a_data,
  output logic             w_load,
  output logic [ROW_W-1:0] wrow,
  output logic [BUS_W-1:0] wdata,
  output logic [BUS_W-1:0] idata,
  output logic [ARR_N-1:0] icol_valid,
  input  logic [ARR_N-1:0] arr_ovalid
);

  localparam int TO_W = $clog2(DRAIN_TO + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] vcnt_q, vec_q, vec_inc;
  logic [CNT_W-1:0] res_q [ARR_N];
  logic [ROW_W-1:0] row_q;
  logic [TO_W-1:0]  to_q;
  logic             accept, w_hs, a_hs, counting;
  logic             all_rows, overflow, pending, complete, expire;

  assign accept   = (state == S_IDLE) && start;
  assign w_hs     = (state == S_LOAD_W) && w_valid;
  assign a_hs     = (state == S_STREAM) && a_valid;
  assign counting = (state == S_STREAM) || (state == S_DRAIN);
  assign vec_inc  = vec_q + 1'b1;

  assign busy    = (state != S_IDLE);
  assign w_ready = (state == S_LOAD_W);
  assign a_ready = (state == S_STREAM);

  always_comb begin
    all_rows = 1'b1;
    overflow = 1'b0;
    for (int r = 0; r < ARR_N; r++) begin
      if (res_q[r] != vcnt_q) all_rows = 1'b0;
      if (counting && arr_ovalid[r] && (res_q[r] == vcnt_q)) overflow = 1'b1;
    end
  end

  // Completion wins over a coinciding timeout, so expire only raises ERR alone.
  assign complete = (state == S_DRAIN) && all_rows && !pending;
  assign expire   = (state == S_DRAIN) && (arr_ovalid == '0) && (to_q == TO_W'(DRAIN_TO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD_W;
      S_LOAD_W: if (w_hs && (row_q == ROW_W'(ARR_N - 1)))
                  state_nxt = (vcnt_q == '0) ? S_DRAIN : S_STREAM;
      S_STREAM: if (a_hs && (vec_inc == vcnt_q)) state_nxt = S_DRAIN;
      S_DRAIN:  if (complete || expire) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vcnt_q <= '0;
      vec_q  <= '0;
      row_q  <= '0;
      w_load <= 1'b0;
      wrow   <= '0;
      wdata  <= '0;
    end else begin
      w_load <= w_hs;
      if (accept) begin
        vcnt_q <= vec_cnt;
        vec_q  <= '0;
        row_q  <= '0;
      end else begin
        if (w_hs) begin
          wrow  <= row_q;
          wdata <= w_data;
          row_q <= row_q + 1'b1;
        end
        if (a_hs) vec_q <= vec_inc;
      end
    end
  end

  // Per-row result counters saturate at the job length; extra results flag ERR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ARR_N; r++) res_q[r] <= '0;
      err  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= complete || expire;
      if (accept) begin
        for (int r = 0; r < ARR_N; r++) res_q[r] <= '0;
        err <= 1'b0;
      end else begin
        if (overflow || (expire && !complete)) err <= 1'b1;
        if (counting) begin
          for (int r = 0; r < ARR_N; r++)
            if (arr_ovalid[r] && (res_q[r] != vcnt_q)) res_q[r] <= res_q[r] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       to_q <= '0;
    else if ((state != S_DRAIN) || (arr_ovalid != '0)) to_q <= '0;
    else                                           to_q <= to_q + 1'b1;
  end

  mac_skew u_skew (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_hs),
    .in_data   (a_data),
    .out_data  (idata),
    .out_valid (icol_valid),
    .pending   (pending)
  );

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomized scoreboard bench for mac_seq_ctrl: drivers push expected weight
// loads, column arrivals and job completions; a negedge monitor pops and compares.
module tb_mac_seq_ctrl;
  import mac_pkg::*;

  localparam int CNT_W    = 8;
  localparam int DRAIN_TO = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] vec_cnt = '0;
  logic             busy, done, err;
  logic             w_valid = 1'b0;
  logic             w_ready;
  logic [31:0]      w_data = '0;
  logic             a_valid = 1'b0;
  logic             a_ready;
  logic [31:0]      a_data = '0;
  logic             w_load;
  logic [1:0]       wrow;
  logic [31:0]      wdata, idata;
  logic [3:0]       icol_valid;
  logic [3:0]       arr_ovalid = '0;

  mac_seq_ctrl #(.CNT_W(CNT_W), .DRAIN_TO(DRAIN_TO)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_cnt(vec_cnt),
    .busy(busy), .done(done), .err(err),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .w_load(w_load), .wrow(wrow), .wdata(wdata),
    .idata(idata), .icol_valid(icol_valid), .arr_ovalid(arr_ovalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; logic [1:0] row; logic [31:0] data; } w_exp_t;
  typedef struct { int cyc; logic [7:0] b; } col_exp_t;
  typedef struct { int cyc; logic err; } done_exp_t;

  w_exp_t    w_q[$];
  col_exp_t  col_q[4][$];
  done_exp_t done_q[$];

  logic [31:0] wts[4];
  logic [31:0] avec[16];
  int          agap[16];
  int          last_hs = 0;

  task automatic check_output(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=absent-or-extra required=one-matching-event (cycle %0d)", name, cyc);
  endtask

  task automatic clear_model();
    w_q.delete();
    done_q.delete();
    for (int j = 0; j < 4; j++) col_q[j].delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check_output(name, {busy, done, err, w_ready, a_ready, w_load, wrow, wdata, idata, icol_valid}, '0);
  endtask

  // Monitor: every DUT output event must match the head of its expectation queue.
  always @(negedge clk) begin : monitor
    w_exp_t    we;
    col_exp_t  ce;
    done_exp_t de;
    if (w_load) begin
      if (w_q.size() == 0) flag_fail("w_load_unexpected");
      else begin
        we = w_q.pop_front();
        check_output("w_load", {cyc, wrow, wdata}, {we.cyc, we.row, we.data});
      end
    end else if (w_q.size() != 0 && w_q[0].cyc < cyc) begin
      void'(w_q.pop_front());
      flag_fail("w_load_missing");
    end
    for (int j = 0; j < 4; j++) begin
      if (icol_valid[j]) begin
        if (col_q[j].size() == 0) flag_fail("icol_unexpected");
        else begin
          ce = col_q[j].pop_front();
          check_output("icol_data", {j, cyc, idata[31-8*j -: 8]}, {j, ce.cyc, ce.b});
        end
      end else begin
        check_output("idata_bubble", idata[31-8*j -: 8], 8'h00);
        if (col_q[j].size() != 0 && col_q[j][0].cyc < cyc) begin
          void'(col_q[j].pop_front());
          flag_fail("icol_missing");
        end
      end
    end
    if (done) begin
      if (done_q.size() == 0) flag_fail("done_unexpected");
      else begin
        de = done_q.pop_front();
        if (de.cyc >= 0) check_output("done_cycle_err", {cyc, err}, {de.cyc, de.err});
        else             check_output("done_err", err, de.err);
      end
    end else if (done_q.size() != 0 && done_q[0].cyc >= 0 && done_q[0].cyc < cyc) begin
      void'(done_q.pop_front());
      flag_fail("done_missing");
    end
  end

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 400) begin @(negedge clk); k++; end
    if (busy) flag_fail("idle_timeout");
    @(posedge clk); #1;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [1:0] row);
    int n = 0;
    w_exp_t e;
    w_valid = 1'b1;
    w_data  = d;
    @(negedge clk);
    while (!w_ready && n < 50) begin @(negedge clk); n++; end
    if (w_ready) begin
      e.cyc = cyc + 1; e.row = row; e.data = d;
      w_q.push_back(e);
      last_hs = cyc;
    end else flag_fail("w_handshake_timeout");
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic send_a(input logic [31:0] d);
    int n = 0;
    col_exp_t e;
    a_valid = 1'b1;
    a_data  = d;
    @(negedge clk);
    while (!a_ready && n < 50) begin @(negedge clk); n++; end
    if (a_ready) begin
      for (int j = 0; j < 4; j++) begin
        e.cyc = cyc + 1 + j;
        e.b   = d[31-8*j -: 8];
        col_q[j].push_back(e);
      end
      last_hs = cyc;
    end else flag_fail("a_handshake_timeout");
    @(posedge clk); #1;
    a_valid = 1'b0;
    a_data  = '0;
  endtask

  task automatic begin_job(input int n, input bit glitch);
    wait_idle();
    start   = 1'b1;
    vec_cnt = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_output("start_accept", {busy, err, w_ready, a_ready}, {1'b1, 1'b0, 1'b1, 1'b0});
    if (glitch) begin
      start   = 1'b1;
      vec_cnt = CNT_W'($urandom_range(1, 200));
    end
    @(posedge clk); #1;
    start = 1'b0;
    for (int r = 0; r < 4; r++) send_w(wts[r], 2'(r));
  endtask

  // Array stand-in: n results per row; with extra, row 0 reports one too many.
  task automatic drive_array(input int n, input bit extra);
    int need[4];
    int guard = 0;
    logic [3:0] m;
    for (int r = 0; r < 4; r++) need[r] = n;
    if (extra) begin
      repeat (n + 1) begin arr_ovalid = 4'b0001; @(posedge clk); #1; end
      arr_ovalid = '0;
      need[0] = 0;
    end
    while ((need[0] + need[1] + need[2] + need[3]) != 0 && guard < 500) begin
      m = 4'($urandom_range(0, 15));
      for (int r = 0; r < 4; r++) begin
        if (need[r] == 0) m[r] = 1'b0;
        if (m[r]) need[r]--;
      end
      arr_ovalid = m;
      @(posedge clk); #1;
      guard++;
    end
    arr_ovalid = '0;
  endtask

  task automatic run_job(input int n, input bit silent, input bit extra, input bit glitch);
    done_exp_t de;
    int k = 0;
    begin_job(n, glitch);
    for (int i = 0; i < n; i++) begin
      repeat (agap[i]) begin @(posedge clk); #1; end
      send_a(avec[i]);
    end
    if (silent && n > 0) begin
      de.cyc = last_hs + 1 + DRAIN_TO;
      de.err = 1'b1;
    end else begin
      de.cyc = -1;
      de.err = extra;
    end
    done_q.push_back(de);
    if (!silent) drive_array(n, extra);
    while (done_q.size() != 0 && k < DRAIN_TO + 300) begin @(negedge clk); k++; end
    if (done_q.size() != 0) begin
      flag_fail("done_timeout");
      done_q.delete();
    end
    @(negedge clk);
    check_output("queues_drained", w_q.size() + col_q[0].size() + col_q[1].size()
                 + col_q[2].size() + col_q[3].size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic apply_stimulus();
    int  n;
    bit  silent, extra;
    n      = $urandom_range(1, 6);
    silent = ($urandom_range(0, 5) == 0);
    extra  = !silent && ($urandom_range(0, 3) == 0);
    for (int r = 0; r < 4; r++) wts[r] = $urandom;
    for (int i = 0; i < 16; i++) begin
      avec[i] = $urandom;
      agap[i] = $urandom_range(0, 2);
    end
    run_job(n, silent, extra, 1'($urandom_range(0, 1)));
  endtask

  task automatic reset_mid_stream();
    for (int i = 0; i < 16; i++) agap[i] = 0;
    begin_job(4, 1'b0);
    send_a(32'hA1B2C3D4);
    send_a(32'h01020304);
    rst = 1'b1;
    clear_model();
    @(negedge clk);
    check_reset_outputs("reset_mid_stream");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_output("post_reset_idle", {busy, done, err, icol_valid}, '0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;

    wts  = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
    for (int i = 0; i < 16; i++) begin avec[i] = $urandom; agap[i] = 0; end
    avec[0] = 32'h11223344;
    avec[1] = 32'h55667788;
    run_job(2, 1'b0, 1'b0, 1'b0);

    agap[1] = 1;
    run_job(3, 1'b0, 1'b0, 1'b0);
    agap[1] = 0;

    run_job(2, 1'b1, 1'b0, 1'b0);
    run_job(0, 1'b0, 1'b0, 1'b0);

    reset_mid_stream();
    run_job(1, 1'b0, 1'b0, 1'b0);

    run_job(3, 1'b0, 1'b1, 1'b0);
    run_job(2, 1'b0, 1'b0, 1'b1);

    repeat (12) apply_stimulus();

    repeat (5) @(negedge clk);
    check_output("final_queues_empty", done_q.size() + w_q.size() + col_q[0].size()
                 + col_q[1].size() + col_q[2].size() + col_q[3].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    flag_fail("global_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
